// File: rtl/coin_acceptor.sv
// coin_acceptor: front-end coin stage for the quarter-counting ticket FSM.
// Synchronises the raw optical sensor and filters short low glitches. It
// measures how long a coin occludes the beam and classifies the passage as
// a quarter or a reject. Each accepted quarter gives exactly one
// quarter_slot pulse, which is held off while the downstream FSM is
// issuing a ticket.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   coin_sense    raw asynchronous sensor, high while a coin occludes the beam
//   ticket        downstream ticket pulse; quarter_slot is deferred while high
//   jam_clr       clears the jam state (only honoured with the beam clear)
//   quarter_slot  one-cycle pulse per accepted quarter
//   reject_gate   drives the reject flap
//   jam           sticky jam indicator
//   quarter_count accepted quarters since reset, wraps 255->0
//   busy          high whenever a passage is being handled (state != IDLE)
module coin_acceptor #(
   parameter int CNT_W         = 12,
   parameter int Q_MIN         = 40,
   parameter int Q_MAX         = 60,
   parameter int DEB           = 3,
   parameter int JAM_CYCLES    = 1000,
   parameter int REJECT_CYCLES = 50
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       coin_sense,
   input  logic       ticket,
   input  logic       jam_clr,
   output logic       quarter_slot,
   output logic       reject_gate,
   output logic       jam,
   output logic [7:0] quarter_count,
   output logic       busy
);

   localparam int LW = $clog2(DEB + 1);
   localparam int RW = $clog2(REJECT_CYCLES + 1);

   localparam logic [CNT_W-1:0] W_MIN = CNT_W'(Q_MIN);
   localparam logic [CNT_W-1:0] W_MAX = CNT_W'(Q_MAX);
   localparam logic [CNT_W-1:0] W_JAM = CNT_W'(JAM_CYCLES);
   localparam logic [LW-1:0]    L_END = LW'(DEB);
   localparam logic [RW-1:0]    R_END = RW'(REJECT_CYCLES - 1);

   if (!(Q_MIN <= Q_MAX && Q_MAX < JAM_CYCLES && JAM_CYCLES <= (2**CNT_W) - 1 &&
         DEB >= 1 && REJECT_CYCLES >= 1)) begin : g_bad_params
      $error("coin_acceptor: illegal parameter set");
   end

   typedef enum logic [2:0] {
      IDLE, MEASURE, CLASSIFY, PULSE, REJECT, GAP, JAM
   } state_t;

   state_t           state, state_nx;
   logic [1:0]       sync;
   logic             sense_s;
   logic [CNT_W-1:0] width, width_nx;
   logic [LW-1:0]    low_run, low_nx;
   logic [RW-1:0]    rej_cnt, rej_nx;
   logic [7:0]       count_nx;

   assign sense_s = sync[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync          <= '0;
         state         <= IDLE;
         width         <= '0;
         low_run       <= '0;
         rej_cnt       <= '0;
         quarter_count <= '0;
      end else begin
         sync          <= {sync[0], coin_sense};
         state         <= state_nx;
         width         <= width_nx;
         low_run       <= low_nx;
         rej_cnt       <= rej_nx;
         quarter_count <= count_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      width_nx     = width;
      low_nx       = low_run;
      rej_nx       = rej_cnt;
      count_nx     = quarter_count;
      quarter_slot = 1'b0;
      case (state)
         IDLE: begin
            low_nx = '0;
            rej_nx = '0;
            if (sense_s) begin
               width_nx = CNT_W'(1);
               state_nx = MEASURE;
            end
         end
         MEASURE: begin
            // Low cycles shorter than DEB are glitches: they neither end the
            // passage nor add to the width.
            if (sense_s) begin
               if (width != '1) width_nx = width + CNT_W'(1);
               low_nx = '0;
            end else begin
               low_nx = low_run + LW'(1);
            end
            // Jam wins over a completed low run in the same cycle.
            if (width_nx >= W_JAM)    state_nx = JAM;
            else if (low_nx == L_END) state_nx = CLASSIFY;
         end
         CLASSIFY: begin
            low_nx = '0;
            rej_nx = '0;
            state_nx = (width >= W_MIN && width <= W_MAX) ? PULSE : REJECT;
         end
         PULSE: begin
            // Hold the pulse while a ticket is being issued so the coin is
            // never lost in the downstream FSM's busy cycle.
            if (!ticket) begin
               quarter_slot = 1'b1;
               count_nx     = quarter_count + 8'd1;
               low_nx       = '0;
               state_nx     = GAP;
            end
         end
         REJECT: begin
            rej_nx = rej_cnt + RW'(1);
            if (rej_cnt == R_END) begin
               low_nx   = '0;
               state_nx = GAP;
            end
         end
         GAP: begin
            // Remaining occlusion of the same coin is absorbed here rather
            // than starting a second measurement.
            if (sense_s) begin
               low_nx = '0;
            end else begin
               low_nx = low_run + LW'(1);
               if (low_nx == L_END) state_nx = IDLE;
            end
         end
         JAM: begin
            if (jam_clr && !sense_s) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Decoded from the state register so they drop with the async reset.
   assign reject_gate = (state == REJECT) || (state == JAM);
   assign jam         = (state == JAM);
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a table of coin passages with
// hand-computed pulse position, reject length and count, plus hand-written
// sequences for jam, reset during operation and the count wrap.
module tb_coin_acceptor;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       coin_sense, ticket, jam_clr;
   logic       quarter_slot, reject_gate, jam, busy;
   logic [7:0] quarter_count;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_count = 8'd0;

   always #5 clk = ~clk;

   coin_acceptor dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .coin_sense   (coin_sense),
      .ticket       (ticket),
      .jam_clr      (jam_clr),
      .quarter_slot (quarter_slot),
      .reject_gate  (reject_gate),
      .jam          (jam),
      .quarter_count(quarter_count),
      .busy         (busy)
   );

   // hi1 high, glen low, hi2 high, then low. Ticket held tk cycles from the
   // PULSE cycle. pulse_at: negedges after coin_sense drops (-1 = none).
   typedef struct {
      string name;
      int    hi1, glen, hi2, tk;
      int    pulse_at;
      int    rej;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic run_coin(input vec_t v);
      int d, last, pulses, first, rej;
      d      = v.hi1 + v.glen + v.hi2;
      last   = d + 12 + v.tk + ((v.rej > 0) ? 56 : 0);
      pulses = 0;
      first  = -1;
      rej    = 0;
      for (int i = 0; i <= last; i++) begin
         @(negedge clk);
         coin_sense = (i < v.hi1) || (i >= v.hi1 + v.glen && i < d);
         ticket     = (v.tk > 0) && (i >= d + 6) && (i < d + 6 + v.tk);
         #1;
         if (quarter_slot) begin
            pulses++;
            if (first < 0) first = i - d;
         end
         if (reject_gate) rej++;
      end
      coin_sense = 1'b0;
      ticket     = 1'b0;
      if (v.pulse_at >= 0) exp_count = exp_count + 8'd1;
      chk({v.name, "_pulses"}, pulses, (v.pulse_at >= 0) ? 1 : 0);
      chk({v.name, "_pulse_at"}, first, v.pulse_at);
      chk({v.name, "_reject"}, rej, v.rej);
      chk({v.name, "_count"}, quarter_count, exp_count);
      chk({v.name, "_idle"}, busy, 0);
   endtask

   // Runs n quiet cycles and reports any pulse/reject seen.
   task automatic quiet(input int n, output int pulses, output int rej);
      pulses = 0;
      rej    = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         if (quarter_slot) pulses++;
         if (reject_gate) rej++;
      end
   endtask

   initial begin
      vec_t vecs[8];
      vec_t q;
      int   p, r, jam_first, seen;

      vecs[0] = '{"w50",   50, 0,  0, 0,  6,  0};
      vecs[1] = '{"w39",   39, 0,  0, 0, -1, 50};
      vecs[2] = '{"w61",   61, 0,  0, 0, -1, 50};
      vecs[3] = '{"w40",   40, 0,  0, 0,  6,  0};
      vecs[4] = '{"w60",   60, 0,  0, 0,  6,  0};
      vecs[5] = '{"glit2", 20, 2, 30, 0,  6,  0};
      vecs[6] = '{"glit3", 20, 3, 30, 0, -1, 50};
      vecs[7] = '{"tick4", 50, 0,  0, 4, 10,  0};

      reset_n    = 1'b0;
      coin_sense = 1'b0;
      ticket     = 1'b0;
      jam_clr    = 1'b0;
      #1;
      chk("reset_outputs", {quarter_slot, reject_gate, jam, busy, quarter_count}, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // jam_clr while idle does nothing
      jam_clr = 1'b1;
      quiet(4, p, r);
      jam_clr = 1'b0;
      chk("idle_jamclr", {jam, busy, reject_gate}, 0);

      foreach (vecs[k]) run_coin(vecs[k]);

      // Jam: width reaches 1000 at negedge 1002. jam_clr while the beam is
      // blocked (1100..1104, and 1201 while sense_s is still high) is ignored.
      jam_first = -1;
      seen      = 0;
      for (int i = 0; i <= 1215; i++) begin
         @(negedge clk);
         coin_sense = (i < 1200);
         jam_clr    = (i >= 1100 && i < 1105) || (i == 1201) || (i == 1210);
         #1;
         if (jam && jam_first < 0) jam_first = i;
         if (quarter_slot) seen++;
         if (i == 1104) chk("jam_clr_blocked", {jam, reject_gate}, 2'b11);
         if (i == 1203) chk("jam_clr_sense_hi", {jam, reject_gate}, 2'b11);
         if (i == 1211) chk("jam_cleared", {jam, reject_gate, busy}, 0);
      end
      jam_clr = 1'b0;
      chk("jam_at_1000", jam_first, 1002);
      chk("jam_no_pulse", seen, 0);
      chk("jam_count", quarter_count, exp_count);

      // Reset mid-MEASURE (width 30 after negedge 32)
      for (int i = 0; i <= 32; i++) begin
         @(negedge clk);
         coin_sense = 1'b1;
      end
      #2 reset_n = 1'b0;
      #1;
      chk("rst_measure_out", {quarter_slot, reject_gate, jam, busy, quarter_count}, 0);
      exp_count = 8'd0;
      coin_sense = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      quiet(80, p, r);
      chk("rst_measure_after", {p[7:0], r[7:0], busy, quarter_count}, 0);

      // Reset mid-REJECT
      seen = 0;
      for (int i = 0; i < 150 && seen < 10; i++) begin
         @(negedge clk);
         coin_sense = (i < 39);
         #1;
         if (reject_gate) seen++;
      end
      chk("rej_started", seen, 10);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_reject_out", {quarter_slot, reject_gate, jam, busy, quarter_count}, 0);
      coin_sense = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      quiet(80, p, r);
      chk("rst_reject_after", {p[7:0], r[7:0], busy, quarter_count}, 0);

      // 256 quarters: count wraps back to 0
      q = '{"wrap", 45, 0, 0, 0, 6, 0};
      for (int n = 0; n < 256; n++) run_coin(q);
      chk("wrap_zero", quarter_count, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
